// File: rtl/score_pkg.sv
// Shared types and helpers for the round-robin BCD score scheduler.
package score_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam int MAX_PLAYERS = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INC,
        S_WRITE
    } state_t;

    // First set bit at or above ptr, wrapping modulo n; returns ptr when nothing is set.
    function automatic int rr_pick(input logic [MAX_PLAYERS-1:0] pend, input int ptr, input int n);
        int idx;
        rr_pick = ptr;
        for (int i = n - 1; i >= 0; i--) begin
            idx = (ptr + i) % n;
            if (pend[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/score_rr_sched_if.sv
// Key-request / score-update bundle between the debouncers, the scheduler and the display mux.
interface score_rr_sched_if
    import score_pkg::*;
#(
    parameter int N_PLAYERS = 2,
    parameter int DIGITS    = 3,
    parameter int ID_W      = 1
);
    logic [N_PLAYERS-1:0]              key_pulse;
    logic                              clr;
    logic [N_PLAYERS*BCD_W*DIGITS-1:0] score_flat;
    logic                              busy;
    logic                              upd_valid;
    logic [ID_W-1:0]                   upd_id;
    logic                              drop;

    modport master (
        output key_pulse, clr,
        input  score_flat, busy, upd_valid, upd_id, drop
    );

    modport slave (
        input  key_pulse, clr,
        output score_flat, busy, upd_valid, upd_id, drop
    );
endinterface

// File: rtl/score_rr_sched_bcd_digit_inc.sv
// Single-digit BCD incrementer shared by all players; the scheduler walks it across digits.
module bcd_digit_inc
    import score_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             cin,
    output logic [BCD_W-1:0] sum,
    output logic             cout
);
    always_comb begin
        sum  = digit;
        cout = 1'b0;
        if (cin) begin
            if (digit >= BCD_MAX) begin
                sum  = '0;
                cout = 1'b1;
            end else begin
                sum = digit + 1'b1;
            end
        end
    end
endmodule

// File: rtl/score_rr_sched.sv
// Round-robin scheduler granting one player at a time to a shared one-digit-per-cycle BCD incrementer.
module score_rr_sched
    import score_pkg::*;
#(
    parameter int N_PLAYERS = 2,
    parameter int DIGITS    = 3,
    parameter int ID_W      = 1
)(
    input logic             clk,
    input logic             rst,
    score_rr_sched_if.slave bus
);
    localparam int SCORE_W = BCD_W * DIGITS;
    localparam int K_W     = $clog2(DIGITS + 1);
    // Digit index DIGITS is an extra slot spent when a carry leaves the top digit (999 -> 000).
    localparam logic [K_W-1:0] K_OVF = K_W'(DIGITS);

    state_t               state, state_nxt;
    logic [K_W-1:0]       dig_k, dig_k_nxt, dig_sel;
    logic [ID_W-1:0]      winner, winner_nxt, rr_ptr, rr_ptr_nxt;
    logic [SCORE_W-1:0]   work, work_nxt;
    logic [SCORE_W-1:0]   score [N_PLAYERS];
    logic [N_PLAYERS-1:0] pend, pend_nxt, grant_mask;
    logic                 do_write, drop_nxt;
    logic [BCD_W-1:0]     dig_in, dig_out;
    logic                 dig_cout;
    logic                 busy_r, upd_valid_r, drop_r;
    logic [ID_W-1:0]      upd_id_r;

    assign dig_sel = (dig_k < K_OVF) ? dig_k : '0;
    assign dig_in  = work[int'(dig_sel)*BCD_W +: BCD_W];

    bcd_digit_inc u_inc (
        .digit (dig_in),
        .cin   (1'b1),
        .sum   (dig_out),
        .cout  (dig_cout)
    );

    always_comb begin
        state_nxt  = state;
        dig_k_nxt  = dig_k;
        winner_nxt = winner;
        work_nxt   = work;
        rr_ptr_nxt = rr_ptr;
        grant_mask = '0;
        do_write   = 1'b0;
        case (state)
            S_IDLE: begin
                if (|pend) begin
                    winner_nxt = ID_W'(rr_pick(MAX_PLAYERS'(pend), int'(rr_ptr), N_PLAYERS));
                    work_nxt   = score[winner_nxt];
                    grant_mask = N_PLAYERS'(1) << winner_nxt;
                    dig_k_nxt  = '0;
                    state_nxt  = S_INC;
                end
            end
            S_INC: begin
                if (dig_k == K_OVF) begin
                    state_nxt = S_WRITE;
                end else begin
                    work_nxt[int'(dig_sel)*BCD_W +: BCD_W] = dig_out;
                    if (dig_cout) dig_k_nxt = dig_k + 1'b1;
                    else          state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                do_write   = 1'b1;
                rr_ptr_nxt = (int'(winner) == N_PLAYERS - 1) ? '0 : winner + 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A new press always survives a same-cycle grant; a press on a still-pending player is lost.
    assign pend_nxt = (pend & ~grant_mask) | bus.key_pulse;
    assign drop_nxt = |(bus.key_pulse & pend & ~grant_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            dig_k       <= '0;
            winner      <= '0;
            rr_ptr      <= '0;
            pend        <= '0;
            busy_r      <= 1'b0;
            upd_valid_r <= 1'b0;
            upd_id_r    <= '0;
            drop_r      <= 1'b0;
            for (int p = 0; p < N_PLAYERS; p++) score[p] <= '0;
        end else if (bus.clr) begin
            state       <= S_IDLE;
            dig_k       <= '0;
            winner      <= '0;
            rr_ptr      <= '0;
            pend        <= '0;
            busy_r      <= 1'b0;
            upd_valid_r <= 1'b0;
            upd_id_r    <= '0;
            drop_r      <= 1'b0;
            for (int p = 0; p < N_PLAYERS; p++) score[p] <= '0;
        end else begin
            state       <= state_nxt;
            dig_k       <= dig_k_nxt;
            winner      <= winner_nxt;
            rr_ptr      <= rr_ptr_nxt;
            pend        <= pend_nxt;
            busy_r      <= (state_nxt != S_IDLE);
            upd_valid_r <= do_write;
            drop_r      <= drop_nxt;
            if (do_write) begin
                upd_id_r      <= winner;
                score[winner] <= work;
            end
        end
    end

    // Working copy is only meaningful between grant and write, so it carries no reset.
    always_ff @(posedge clk) begin
        work <= work_nxt;
    end

    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_flat
        assign bus.score_flat[p*SCORE_W +: SCORE_W] = score[p];
    end

    assign bus.busy      = busy_r;
    assign bus.upd_valid = upd_valid_r;
    assign bus.upd_id    = upd_id_r;
    assign bus.drop      = drop_r;

endmodule

// File: tb/tb_score_rr_sched.sv
// Directed bench for score_rr_sched: two players, three BCD digits.
module tb_score_rr_sched;
    localparam int N  = 2;
    localparam int D  = 3;
    localparam int IW = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    int   cnt;

    score_rr_sched_if #(.N_PLAYERS(N), .DIGITS(D), .ID_W(IW)) bus ();

    score_rr_sched #(.N_PLAYERS(N), .DIGITS(D), .ID_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [1:0] v);
        bus.key_pulse = v;
        tick();
        bus.key_pulse = '0;
    endtask

    task automatic wait_upd(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.upd_valid !== 1'b1 && n < 20);
        if (bus.upd_valid !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL upd_timeout: observed=%0b expected=1", bus.upd_valid);
        end
    endtask

    task automatic add_points(input int p, input int n);
        int l;
        repeat (n) begin
            press(2'(1 << p));
            wait_upd(l);
        end
    endtask

    task automatic quiet_cycles(output int c);
        c = 0;
        repeat (8) begin
            tick();
            if (bus.upd_valid === 1'b1) c++;
        end
    endtask

    initial begin
        bus.key_pulse = '0;
        bus.clr       = 1'b0;
        tick();
        tick();
        check("rst_score", bus.score_flat, 24'h000000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_upd_valid", bus.upd_valid, 1'b0);
        check("rst_upd_id", bus.upd_id, 1'b0);
        check("rst_drop", bus.drop, 1'b0);
        rst = 1'b0;
        tick();

        // single press, no carry
        press(2'b01);
        wait_upd(lat);
        check("t1_latency", lat, 3);
        check("t1_upd_id", bus.upd_id, 1'b0);
        check("t1_score", bus.score_flat, 24'h000001);
        check("t1_busy", bus.busy, 1'b0);

        // two-digit carry 099 -> 100
        add_points(0, 98);
        check("t2_preload", bus.score_flat, 24'h000099);
        press(2'b01);
        wait_upd(lat);
        check("t2_latency", lat, 5);
        check("t2_score", bus.score_flat, 24'h000100);

        // wrap 999 -> 000
        add_points(1, 999);
        check("t3_preload", bus.score_flat, 24'h999100);
        press(2'b10);
        wait_upd(lat);
        check("t3_latency", lat, 6);
        check("t3_upd_id", bus.upd_id, 1'b1);
        check("t3_score", bus.score_flat, 24'h000100);
        check("t3_drop", bus.drop, 1'b0);

        // simultaneous presses with pointer at 0
        press(2'b11);
        wait_upd(lat);
        check("t4a_first_id", bus.upd_id, 1'b0);
        check("t4a_first_score", bus.score_flat, 24'h000101);
        wait_upd(lat);
        check("t4a_second_lat", lat, 3);
        check("t4a_second_id", bus.upd_id, 1'b1);
        check("t4a_second_score", bus.score_flat, 24'h001101);

        // move pointer to 1, then simultaneous presses favour player 1
        add_points(0, 1);
        check("t4b_pre_score", bus.score_flat, 24'h001102);
        press(2'b11);
        wait_upd(lat);
        check("t4b_first_id", bus.upd_id, 1'b1);
        check("t4b_first_score", bus.score_flat, 24'h002102);
        wait_upd(lat);
        check("t4b_second_id", bus.upd_id, 1'b0);
        check("t4b_second_score", bus.score_flat, 24'h002103);

        // double press of pending player 0 while player 1 is in flight
        press(2'b10);
        press(2'b01);
        check("t5_drop_first", bus.drop, 1'b0);
        press(2'b01);
        check("t5_drop_second", bus.drop, 1'b1);
        wait_upd(lat);
        check("t5_drop_clears", bus.drop, 1'b0);
        check("t5_p1_id", bus.upd_id, 1'b1);
        check("t5_p1_score", bus.score_flat, 24'h003103);
        wait_upd(lat);
        check("t5_p0_id", bus.upd_id, 1'b0);
        check("t5_p0_score", bus.score_flat, 24'h003104);
        quiet_cycles(cnt);
        check("t5_no_extra_upd", cnt, 0);
        check("t5_busy", bus.busy, 1'b0);

        // clr wins over a same-cycle key press
        bus.clr       = 1'b1;
        bus.key_pulse = 2'b01;
        tick();
        bus.clr       = 1'b0;
        bus.key_pulse = '0;
        check("t6_clr_score", bus.score_flat, 24'h000000);
        tick();
        check("t6_clr_ignores_key", bus.busy, 1'b0);

        // clr during INC of 099 -> 100
        add_points(0, 99);
        check("t6_preload", bus.score_flat, 24'h000099);
        press(2'b01);
        tick();
        check("t6_busy_inflight", bus.busy, 1'b1);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        check("t6_abort_upd", bus.upd_valid, 1'b0);
        check("t6_abort_busy", bus.busy, 1'b0);
        check("t6_abort_score", bus.score_flat, 24'h000000);
        quiet_cycles(cnt);
        check("t6_no_late_upd", cnt, 0);

        // rr pointer back to 0 after clr
        press(2'b11);
        wait_upd(lat);
        check("t6_rr_first_id", bus.upd_id, 1'b0);
        wait_upd(lat);
        check("t6_rr_second_id", bus.upd_id, 1'b1);
        check("t6_rr_score", bus.score_flat, 24'h001001);

        // asynchronous reset mid-operation
        press(2'b10);
        tick();
        check("t7_busy_inflight", bus.busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("t7_async_busy", bus.busy, 1'b0);
        check("t7_async_score", bus.score_flat, 24'h000000);
        check("t7_async_upd", bus.upd_valid, 1'b0);
        tick();
        rst = 1'b0;
        quiet_cycles(cnt);
        check("t7_no_late_upd", cnt, 0);
        check("t7_busy_after", bus.busy, 1'b0);
        check("t7_drop_after", bus.drop, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
